// File: rtl/sram_responder.sv
// sram_responder
//
// Memory-side responder for the core's instruction and data SRAM-style ports.
// Every enabled access is answered with a fixed one-cycle latency. Both ports
// share one word array: the instruction port only reads, the data port reads
// and writes with byte enables. Data accesses whose addr[31:16] equals CONF_HI
// go to a small register block instead of the array.
//
// Parameters
//   ADDR_W   word-address width; the array holds 2^ADDR_W 32-bit words
//   CONF_HI  addr[31:16] value selecting the configuration region
//
// Ports
//   clk              clock, all state updates on the rising edge
//   rst              asynchronous, active-high reset
//   inst_sram_en     instruction read request
//   inst_sram_wen    unused (instruction port never writes)
//   inst_sram_addr   instruction byte address
//   inst_sram_wdata  unused
//   inst_sram_rdata  instruction read data, valid the cycle after the request
//   data_sram_en     data access request
//   data_sram_wen    byte write enables; all zero means read
//   data_sram_addr   data byte address
//   data_sram_wdata  data write data
//   data_sram_rdata  data read data, valid the cycle after the request
//   switch_in        switch levels, readable at offset 0xF020
//   led_out          LED register (offset 0xF000)
//   num_out          number-display register (offset 0xF010)

module sram_responder #(
    parameter int unsigned ADDR_W  = 14,
    parameter logic [15:0] CONF_HI = 16'hBFAF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,

    input  logic [7:0]  switch_in,
    output logic [15:0] led_out,
    output logic [31:0] num_out
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    localparam logic [15:0] OFF_TIMER  = 16'hE000;
    localparam logic [15:0] OFF_LED    = 16'hF000;
    localparam logic [15:0] OFF_NUM    = 16'hF010;
    localparam logic [15:0] OFF_SWITCH = 16'hF020;

    // Replace only the bytes whose enable is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  wen);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0] mem [DEPTH];

    logic [31:0] timer_q, timer_d;
    logic [15:0] led_q, led_d;
    logic [31:0] num_q, num_d;
    logic [31:0] inst_rdata_q;
    logic [31:0] data_rdata_q;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] inst_idx;
    logic [ADDR_W-1:0] data_idx;
    logic [15:0]       data_off;
    logic              data_conf;
    logic              data_wr;
    logic              mem_wr;
    logic              conf_wr;

    // Upper instruction address bits alias, and the byte offset is ignored.
    assign inst_idx  = inst_sram_addr[ADDR_W+1:2];
    assign data_idx  = data_sram_addr[ADDR_W+1:2];
    assign data_off  = data_sram_addr[15:0];
    assign data_conf = (data_sram_addr[31:16] == CONF_HI);
    assign data_wr   = data_sram_en && (data_sram_wen != 4'b0000);
    assign mem_wr    = data_wr && !data_conf;
    assign conf_wr   = data_wr && data_conf;

    logic sel_timer, sel_led, sel_num, sel_switch;

    always_comb begin
        sel_timer  = 1'b0;
        sel_led    = 1'b0;
        sel_num    = 1'b0;
        sel_switch = 1'b0;
        case (data_off)
            OFF_TIMER:  sel_timer  = 1'b1;
            OFF_LED:    sel_led    = 1'b1;
            OFF_NUM:    sel_num    = 1'b1;
            OFF_SWITCH: sel_switch = 1'b1;
            default: ;
        endcase
    end

    // Register read mux; reflects values held during the current cycle so a
    // write cycle returns the pre-write contents.
    logic [31:0] conf_rdata;

    always_comb begin
        conf_rdata = 32'h0;
        if (sel_timer) begin
            conf_rdata = timer_q;
        end else if (sel_led) begin
            conf_rdata = {16'h0, led_q};
        end else if (sel_num) begin
            conf_rdata = num_q;
        end else if (sel_switch) begin
            conf_rdata = {24'h0, switch_in};
        end
    end

    // ------------------------------------------------------------------
    // Configuration register next state
    // ------------------------------------------------------------------
    logic [31:0] led_merged;

    always_comb begin
        // Timer counts every cycle unless this cycle writes it.
        timer_d    = timer_q + 32'd1;
        led_d      = led_q;
        num_d      = num_q;
        led_merged = merge_bytes({16'h0, led_q}, data_sram_wdata, data_sram_wen);

        if (conf_wr && sel_timer) begin
            timer_d = merge_bytes(timer_q, data_sram_wdata, data_sram_wen);
        end
        if (conf_wr && sel_led) begin
            led_d = led_merged[15:0];
        end
        if (conf_wr && sel_num) begin
            num_d = merge_bytes(num_q, data_sram_wdata, data_sram_wen);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= 32'h0;
            led_q   <= 16'h0;
            num_q   <= 32'h0;
        end else begin
            timer_q <= timer_d;
            led_q   <= led_d;
            num_q   <= num_d;
        end
    end

    // ------------------------------------------------------------------
    // Array write port (contents survive reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) begin
                    mem[data_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read response registers
    // ------------------------------------------------------------------
    // Non-blocking reads sample the array before this edge's write lands,
    // giving read-first behaviour on both ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
        end else begin
            if (inst_sram_en) begin
                inst_rdata_q <= mem[inst_idx];
            end
            if (data_sram_en) begin
                data_rdata_q <= data_conf ? conf_rdata : mem[data_idx];
            end
        end
    end

    assign inst_sram_rdata = inst_rdata_q;
    assign data_sram_rdata = data_rdata_q;
    assign led_out         = led_q;
    assign num_out         = num_q;

    // Inputs that carry no meaning on this side of the bus.
    logic unused_bits;
    assign unused_bits = ^{inst_sram_wen, inst_sram_wdata,
                           inst_sram_addr[31:ADDR_W+2], inst_sram_addr[1:0]};

endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;

    localparam int unsigned ADDR_W  = 14;
    localparam logic [15:0] CONF_HI = 16'hBFAF;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [7:0]  switch_in;
    logic [15:0] led_out;
    logic [31:0] num_out;

    sram_responder #(
        .ADDR_W  (ADDR_W),
        .CONF_HI (CONF_HI)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .switch_in       (switch_in),
        .led_out         (led_out),
        .num_out         (num_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: word store keyed by word index, plus register values
    // ------------------------------------------------------------------
    logic [31:0] mem_m [int];
    logic [31:0] timer_m;
    logic [15:0] led_m;
    logic [31:0] num_m;
    logic [31:0] exp_i;
    logic [31:0] exp_d;
    bit          known_i;
    bit          known_d;

    function automatic logic [31:0] apply_wen(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  wen);
        logic [31:0] mask;
        mask = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) mask = mask | (32'hFF << (8 * i));
        end
        return (old_word & ~mask) | (new_word & mask);
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr >> 2) % (32'd1 << ADDR_W));
    endfunction

    function automatic logic [31:0] conf_read(input logic [15:0] off);
        case (off)
            16'hE000: return timer_m;
            16'hF000: return {16'h0, led_m};
            16'hF010: return num_m;
            16'hF020: return {24'h0, switch_in};
            default:  return 32'h0;
        endcase
    endfunction

    // Advance the model by one cycle using the inputs currently driven.
    task automatic model_cycle();
        int          ii;
        int          di;
        bit          conf;
        bit          timer_written;
        logic [31:0] tmp;
        ii            = word_of(inst_sram_addr);
        di            = word_of(data_sram_addr);
        conf          = (data_sram_addr[31:16] == CONF_HI);
        timer_written = 1'b0;

        // Reads see the state before any write of this cycle.
        if (inst_sram_en) begin
            known_i = mem_m.exists(ii);
            exp_i   = known_i ? mem_m[ii] : 32'h0;
        end
        if (data_sram_en) begin
            if (conf) begin
                known_d = 1'b1;
                exp_d   = conf_read(data_sram_addr[15:0]);
            end else begin
                known_d = mem_m.exists(di);
                exp_d   = known_d ? mem_m[di] : 32'h0;
            end
        end

        if (data_sram_en && data_sram_wen != 4'h0) begin
            if (conf) begin
                case (data_sram_addr[15:0])
                    16'hE000: begin
                        timer_m       = apply_wen(timer_m, data_sram_wdata, data_sram_wen);
                        timer_written = 1'b1;
                    end
                    16'hF000: begin
                        tmp   = apply_wen({16'h0, led_m}, data_sram_wdata, data_sram_wen);
                        led_m = tmp[15:0];
                    end
                    16'hF010: num_m = apply_wen(num_m, data_sram_wdata, data_sram_wen);
                    default: ;
                endcase
            end else if (mem_m.exists(di)) begin
                mem_m[di] = apply_wen(mem_m[di], data_sram_wdata, data_sram_wen);
            end else if (data_sram_wen == 4'hF) begin
                mem_m[di] = data_sram_wdata;
            end
        end
        if (!timer_written) timer_m = timer_m + 32'd1;
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        if (known_i) check_eq("inst_rdata", inst_sram_rdata, exp_i);
        if (known_d) check_eq("data_rdata", data_sram_rdata, exp_d);
        check_eq("led_out", {16'h0, led_out}, {16'h0, led_m});
        check_eq("num_out", num_out, num_m);
    endtask

    task automatic drive_i(input bit en, input logic [31:0] addr);
        inst_sram_en    = en;
        inst_sram_addr  = addr;
        inst_sram_wen   = 4'($urandom);
        inst_sram_wdata = $urandom;
    endtask

    task automatic drive_d(input bit en, input logic [3:0] wen, input logic [31:0] addr,
                           input logic [31:0] wdata);
        data_sram_en    = en;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
    endtask

    function automatic logic [31:0] rand_mem_addr(input bit any_hi);
        logic [31:0] hi;
        logic [4:0]  w;
        hi = $urandom;
        w  = 5'($urandom_range(0, 31));
        if (!any_hi && hi[31:16] == CONF_HI) hi[31:16] = 16'h0;
        return {hi[31:16], 9'h0, w, hi[1:0]};
    endfunction

    logic [15:0] conf_offs [6];

    initial begin
        conf_offs = '{16'hE000, 16'hF000, 16'hF010, 16'hF020, 16'hF100, 16'h0000};
        rst = 1'b1;
        switch_in = 8'h00;
        drive_i(1'b0, 32'h0);
        drive_d(1'b0, 4'h0, 32'h0, 32'h0);
        #8;
        check_eq("reset_inst_rdata", inst_sram_rdata, 32'h0);
        check_eq("reset_data_rdata", data_sram_rdata, 32'h0);
        check_eq("reset_led", {16'h0, led_out}, 32'h0);
        check_eq("reset_num", num_out, 32'h0);
        timer_m = 32'h0; led_m = 16'h0; num_m = 32'h0;
        exp_i = 32'h0; exp_d = 32'h0; known_i = 1'b1; known_d = 1'b1;
        #4 rst = 1'b0;

        // Data write then instruction fetch of the same word
        drive_d(1'b1, 4'hF, 32'h0000_0040, 32'h1234_5678); step();
        drive_d(1'b0, 4'h0, 32'h0, 32'h0);
        drive_i(1'b1, 32'h0000_0040); step();
        check_eq("ifetch_after_dwrite", inst_sram_rdata, 32'h1234_5678);
        drive_i(1'b0, 32'h0);

        // Byte-enable merge with read-first response
        drive_d(1'b1, 4'hF, 32'h0000_0044, 32'hAABB_CCDD); step();
        drive_d(1'b1, 4'b0010, 32'h0000_0044, 32'h0000_1100); step();
        check_eq("write_cycle_old_word", data_sram_rdata, 32'hAABB_CCDD);
        drive_d(1'b1, 4'h0, 32'h0000_0044, 32'h0); step();
        check_eq("byte_merge", data_sram_rdata, 32'hAABB_11DD);

        // Same-cycle data write and instruction read of one word
        drive_d(1'b1, 4'hF, 32'h0000_0048, 32'h0); step();
        drive_d(1'b1, 4'hF, 32'h0000_0048, 32'hCAFE_F00D);
        drive_i(1'b1, 32'h0000_0048); step();
        check_eq("same_cycle_read_first", inst_sram_rdata, 32'h0);
        drive_d(1'b0, 4'h0, 32'h0, 32'h0); step();
        check_eq("ifetch_new_word", inst_sram_rdata, 32'hCAFE_F00D);
        drive_i(1'b0, 32'h0); step();
        check_eq("inst_rdata_hold", inst_sram_rdata, 32'hCAFE_F00D);

        // Address aliasing; instruction port never decodes the config region
        drive_d(1'b1, 4'h0, 32'h0001_0042, 32'h0); step();
        check_eq("data_alias", data_sram_rdata, 32'h1234_5678);
        drive_d(1'b0, 4'h0, 32'h0, 32'h0);
        drive_i(1'b1, 32'hBFAF_0040); step();
        check_eq("ifetch_conf_hi_is_mem", inst_sram_rdata, 32'h1234_5678);
        drive_i(1'b0, 32'h0);

        // Timer load and wrap
        drive_d(1'b1, 4'hF, 32'hBFAF_E000, 32'hFFFF_FFFE); step();
        drive_d(1'b1, 4'h0, 32'hBFAF_E000, 32'h0); step();
        check_eq("timer_loaded", data_sram_rdata, 32'hFFFF_FFFE);
        step(); check_eq("timer_max", data_sram_rdata, 32'hFFFF_FFFF);
        step(); check_eq("timer_wrap", data_sram_rdata, 32'h0000_0000);
        step(); check_eq("timer_after_wrap", data_sram_rdata, 32'h0000_0001);

        // LED, switch, unmapped offset, NUM byte merge
        drive_d(1'b1, 4'hF, 32'hBFAF_F000, 32'h0000_BEEF); step();
        check_eq("led_write", {16'h0, led_out}, 32'h0000_BEEF);
        drive_d(1'b1, 4'h0, 32'hBFAF_F000, 32'h0); step();
        check_eq("led_read", data_sram_rdata, 32'h0000_BEEF);
        switch_in = 8'h5A;
        drive_d(1'b1, 4'h0, 32'hBFAF_F020, 32'h0); step();
        check_eq("switch_read", data_sram_rdata, 32'h0000_005A);
        drive_d(1'b1, 4'h0, 32'hBFAF_F100, 32'h0); step();
        check_eq("unmapped_read", data_sram_rdata, 32'h0);
        drive_d(1'b1, 4'b0101, 32'hBFAF_F010, 32'h1122_3344); step();
        check_eq("num_byte_merge", num_out, 32'h0022_0044);

        // Fill a small word window, then randomized traffic on both ports
        for (int w = 0; w < 32; w++) begin
            drive_d(1'b1, 4'hF, 32'(w * 4), $urandom); step();
        end
        for (int n = 0; n < 400; n++) begin
            switch_in = 8'($urandom);
            drive_i(($urandom_range(0, 1) == 1), rand_mem_addr(1'b1));
            if ($urandom_range(0, 9) < 6) begin
                drive_d(($urandom_range(0, 9) < 7),
                        ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
                        rand_mem_addr(1'b0), $urandom);
            end else begin
                drive_d(($urandom_range(0, 9) < 7),
                        ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
                        {CONF_HI, conf_offs[$urandom_range(0, 5)]}, $urandom);
            end
            step();
        end

        // Reset asserted mid-operation
        drive_i(1'b0, 32'h0);
        drive_d(1'b1, 4'hF, 32'hBFAF_F000, 32'h0000_1234); step();
        drive_d(1'b1, 4'h0, 32'h0000_000C, 32'h0); step();
        drive_d(1'b0, 4'h0, 32'h0, 32'h0);
        #2 rst = 1'b1;
        #1;
        check_eq("midreset_data_rdata", data_sram_rdata, 32'h0);
        check_eq("midreset_inst_rdata", inst_sram_rdata, 32'h0);
        check_eq("midreset_led", {16'h0, led_out}, 32'h0);
        check_eq("midreset_num", num_out, 32'h0);
        timer_m = 32'h0; led_m = 16'h0; num_m = 32'h0;
        exp_i = 32'h0; exp_d = 32'h0; known_i = 1'b1; known_d = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        step();
        check_eq("post_reset_rdata_zero", data_sram_rdata, 32'h0);
        drive_d(1'b1, 4'h0, 32'h0000_000C, 32'h0);
        drive_i(1'b1, 32'h0000_000C); step();
        drive_d(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
        drive_i(1'b0, 32'h0); step();
        check_eq("post_reset_timer", data_sram_rdata, 32'h0000_0002);
        drive_d(1'b0, 4'h0, 32'h0, 32'h0); step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
